// File: rtl/dyn_shiftrows_stage.sv
//==============================================================================
// Module   : dyn_shiftrows_stage
// Brief    : Registered dynamic AES ShiftRows stage with valid/ready and a
//            one-deep skid buffer. Optional macro DSR_ROUND_MIX_EN folds
//            round[1:0] into every row rotate amount.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dyn_shiftrows_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_state,
    input  logic [7:0]       shift_key,
    input  logic [3:0]       round,
    input  logic             inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_state,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_in_ready;
    logic [127:0]      r_out_state;
    logic [127:0]      r_skid;
    logic [CNT_W-1:0]  r_blk_cnt;

    logic              w_accept;
    logic              w_xfer;
    logic              w_load_out;
    logic              w_load_skid;
    logic              w_sel_skid;
    logic [7:0]        w_row_amt;
    logic [127:0]      w_shifted;

    // Byte k = 4*c + r sits at [127-8k -: 8]; dir=1 rotates right.
    function automatic logic [127:0] f_rotate_rows(
        input logic [127:0] st,
        input logic [7:0]   amt,
        input logic         dir
    );
        logic [127:0] res;
        logic [1:0]   src;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = dir ? (2'(c) - amt[2*r +: 2]) : (2'(c) + amt[2*r +: 2]);
                res[127-8*(4*c+r) -: 8] = st[127-8*(4*int'(src)+r) -: 8];
            end
        end
        return res;
    endfunction

`ifdef DSR_ROUND_MIX_EN
    logic w_unused_round_hi;
    assign w_unused_round_hi = ^round[3:2];

    always_comb begin
        w_row_amt = '0;
        for (int r = 0; r < 4; r++) begin
            w_row_amt[2*r +: 2] = shift_key[2*r +: 2] + round[1:0];
        end
    end
`else
    logic w_unused_round;
    assign w_unused_round = ^round;
    assign w_row_amt      = shift_key;
`endif

    assign w_shifted = f_rotate_rows(in_state, w_row_amt, inv);

    assign w_accept  = in_valid & r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign w_xfer    = out_valid & out_ready;

    always_comb begin
        w_next_state = r_state;
        w_load_out   = 1'b0;
        w_load_skid  = 1'b0;
        w_sel_skid   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_out   = 1'b1;
                    w_next_state = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_xfer) begin
                    w_load_out = 1'b1;
                end else if (w_accept) begin
                    w_load_skid  = 1'b1;
                    w_next_state = ST_FULL;
                end else if (w_xfer) begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_xfer) begin
                    w_load_out   = 1'b1;
                    w_sel_skid   = 1'b1;
                    w_next_state = ST_ONE;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_state <= '0;
            r_skid      <= '0;
            r_blk_cnt   <= '0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_FULL);
            if (w_load_out) begin
                r_out_state <= w_sel_skid ? r_skid : w_shifted;
            end
            if (w_load_skid) begin
                r_skid <= w_shifted;
            end
            if (w_xfer) begin
                r_blk_cnt <= r_blk_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_state = r_out_state;
    assign blk_cnt   = r_blk_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dyn_shiftrows_stage.sv
//==============================================================================
// Module   : tb_dyn_shiftrows_stage
// Brief    : Self-checking bench for dyn_shiftrows_stage (vectors, scoreboard).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dyn_shiftrows_stage;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_state;
    logic [7:0]       shift_key;
    logic [3:0]       round;
    logic             inv;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_state;
    logic [CNT_W-1:0] blk_cnt;

    int n_tests;
    int n_fail;

    logic [127:0] sb_q[$];

    typedef struct {
        logic [127:0] st;
        logic [7:0]   key;
        logic [3:0]   rnd;
        logic         dir;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[$];

    dyn_shiftrows_stage #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .shift_key (shift_key),
        .round     (round),
        .inv       (inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .blk_cnt   (blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unpack to a byte matrix, rotate each row with modular arithmetic.
    function automatic logic [127:0] ref_shift(input logic [127:0] st, input logic [7:0] key,
                                               input logic [3:0] rnd, input logic dir);
        logic [7:0]   m[4][4];
        logic [127:0] res;
        int           s;
        int           src;
        for (int k = 0; k < 16; k++) m[k % 4][k / 4] = st[127-8*k -: 8];
        res = '0;
        for (int r = 0; r < 4; r++) begin
            s = (key >> (2*r)) & 3;
`ifdef DSR_ROUND_MIX_EN
            s = (s + rnd[1:0]) % 4;
`endif
            for (int c = 0; c < 4; c++) begin
                src = dir ? (c - s + 4) % 4 : (c + s) % 4;
                res[127-8*(4*c+r) -: 8] = m[r][src];
            end
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] st, input logic [7:0] key,
                         input logic [3:0] rnd, input logic dir);
        in_valid  = v;
        in_state  = st;
        shift_key = key;
        round     = rnd;
        inv       = dir;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard: every output transfer must match the oldest accepted block.
    always @(posedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) chk("unexpected_output", out_state, 128'hx);
                else chk("stream_data", out_state, sb_q.pop_front());
            end
            if (in_valid && in_ready)
                sb_q.push_back(ref_shift(in_state, shift_key, round, inv));
        end
    end

    localparam logic [127:0] BASE = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0);

        vecs.push_back('{BASE, 8'hE4, 4'h0, 1'b0, 128'h00050a0f04090e03080d02070c01060b});
        vecs.push_back('{BASE, 8'hE4, 4'h0, 1'b1, 128'h000d0a0704010e0b0805020f0c090603});
        vecs.push_back('{BASE, 8'h00, 4'h0, 1'b0, BASE});
        vecs.push_back('{BASE, 8'h1B, 4'h0, 1'b0, 128'h0c090603000d0a0704010e0b0805020f});
`ifdef DSR_ROUND_MIX_EN
        vecs.push_back('{BASE, 8'h00, 4'h1, 1'b0, 128'h0405060708090a0b0c0d0e0f00010203});
`endif

        step(); step();
        rst = 1'b0;
        step();
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_out_state", out_state, 128'd0);
        chk("reset_blk_cnt", 128'(blk_cnt), 128'd0);
        chk("reset_in_ready", 128'(in_ready), 128'd1);

        // Directed vectors: one cycle latency from an empty stage.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].st, vecs[i].key, vecs[i].rnd, vecs[i].dir);
            step();
            drive(1'b0, '0, '0, '0, 1'b0);
            chk("vec_out_valid", 128'(out_valid), 128'd1);
            chk("vec_out_state", out_state, vecs[i].exp);
            chk("vec_in_ready", 128'(in_ready), 128'd1);
            step();
        end
        chk("vec_blk_cnt", 128'(blk_cnt), 128'(vecs.size()));

        // Backpressure: A then B fill the stage, C must be ignored.
        begin
            logic [127:0] a, b;
            logic [7:0]   ka, kb;
            a = rnd128(); b = rnd128();
            ka = 8'($urandom()); kb = 8'($urandom());
            out_ready = 1'b0;
            drive(1'b1, a, ka, 4'h2, 1'b0);
            step();
            drive(1'b1, b, kb, 4'h3, 1'b1);
            step();
            drive(1'b1, rnd128(), 8'h55, 4'h0, 1'b0);
            chk("bp_in_ready_full", 128'(in_ready), 128'd0);
            chk("bp_hold_a", out_state, ref_shift(a, ka, 4'h2, 1'b0));
            step();
            drive(1'b0, '0, '0, '0, 1'b0);
            chk("bp_still_a", out_state, ref_shift(a, ka, 4'h2, 1'b0));
            chk("bp_still_full", 128'(in_ready), 128'd0);
            out_ready = 1'b1;
            step();
            chk("bp_then_b", out_state, ref_shift(b, kb, 4'h3, 1'b1));
            chk("bp_ready_back", 128'(in_ready), 128'd1);
            step();
            chk("bp_drained", 128'(out_valid), 128'd0);
            chk("bp_blk_cnt", 128'(blk_cnt), 128'(vecs.size() + 2));
        end

        // 20 back-to-back blocks at full throughput.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, rnd128(), 8'($urandom()), 4'($urandom()), 1'($urandom()));
            step();
            chk("stream_in_ready", 128'(in_ready), 128'd1);
            chk("stream_out_valid", 128'(out_valid), 128'd1);
        end
        drive(1'b0, '0, '0, '0, 1'b0);
        step();
        chk("stream_blk_cnt", 128'(blk_cnt), 128'(vecs.size() + 22));

        // Random valid/ready traffic, checked by the scoreboard.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom()), rnd128(), 8'($urandom()), 4'($urandom()), 1'($urandom()));
            out_ready = 1'($urandom());
            step();
        end
        drive(1'b0, '0, '0, '0, 1'b0);
        out_ready = 1'b1;
        begin
            int budget;
            budget = 0;
            while ((out_valid || sb_q.size() != 0) && budget < 5) begin
                step();
                budget++;
            end
            chk("random_drain", 128'(out_valid || sb_q.size() != 0), 128'd0);
        end

        // Reset while FULL discards everything.
        out_ready = 1'b0;
        drive(1'b1, rnd128(), 8'h12, 4'h0, 1'b0);
        step();
        step();
        drive(1'b0, '0, '0, '0, 1'b0);
        chk("full_before_rst", 128'(in_ready), 128'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_full_out_valid", 128'(out_valid), 128'd0);
        chk("rst_full_blk_cnt", 128'(blk_cnt), 128'd0);
        chk("rst_full_in_ready", 128'(in_ready), 128'd1);
        chk("rst_full_out_state", out_state, 128'd0);
        out_ready = 1'b1;
        step();
        chk("rst_full_no_ghost", 128'(out_valid), 128'd0);

        // Counter wrap: 2^CNT_W-1 transfers, then one more.
        drive(1'b1, rnd128(), 8'($urandom()), 4'($urandom()), 1'b0);
        for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
            in_state = rnd128();
            step();
        end
        drive(1'b0, '0, '0, '0, 1'b0);
        step();
        chk("cnt_max", 128'(blk_cnt), 128'hFFFF);
        chk("cnt_max_idle", 128'(out_valid), 128'd0);
        drive(1'b1, BASE, 8'hE4, 4'h0, 1'b0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0);
        step();
        chk("cnt_wrap", 128'(blk_cnt), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dyn_shiftrows_stage.md
Name: dyn_shiftrows_stage

Overview:
Registered Dynamic ShiftRows stage that sits directly downstream of the SubBytes block in the AES round datapath. It accepts the 128-bit SubBytes output through a valid/ready handshake. Each of the four state rows is rotated by a key-selected amount, forward for encryption or inverse for decryption. Results go to the bit-permuted MixColumns stage through a one-deep skid buffer, so the stage runs at full throughput under backpressure.

Parameters:
CNT_W, 16, width of the processed-block counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  input state valid
in_ready  output  1  stage can accept input this cycle
in_state  input  128  SubBytes output; byte k = in_state[127-8k -: 8]; k = 4*c + r (column-major)
shift_key  input  8  per-row rotate amounts; row r uses shift_key[2r+1:2r]
round  input  4  round index; used only with the optional feature
inv  input  1  0 = rotate left (encrypt), 1 = rotate right (decrypt)
out_valid  output  1  output state valid
out_ready  input  1  downstream accepts output
out_state  output  128  shifted state, same byte ordering as in_state
blk_cnt  output  CNT_W  count of output transfers completed

Behaviour:
- Reset: synchronous, active-high. out_valid=0, out_state=0, blk_cnt=0, skid empty, in_ready=1 in the cycle after reset. Reset mid-transfer discards the output register and skid contents.
- Transform (combinational, on accepted input):
  - Row amount s_r = shift_key[2r+1:2r].
  - Forward: out(r,c) = in(r,(c+s_r) mod 4).
  - Inverse: out(r,c) = in(r,(c-s_r) mod 4).
  - shift_key, round and inv are sampled together with in_state on the accept cycle and travel with the data.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_state holds stable while out_valid=1 and out_ready=0.
- State machine (registered occupancy):
  - EMPTY: out_valid=0. On accept: load output register, go to ONE.
  - ONE: out_valid=1, skid empty, in_ready=1.
    - Accept and transfer together: reload output register, stay in ONE.
    - Transfer only: go to EMPTY.
    - Accept only: result goes to skid, go to FULL.
  - FULL: out_valid=1, in_ready=0.
    - On transfer: skid moves to output register, go to ONE.
- in_ready is a registered signal: 1 in EMPTY and ONE, 0 in FULL.
- Latency: 1 cycle from accept to out_valid when the stage is EMPTY. Throughput is 1 block/cycle when out_ready is held at 1.
- blk_cnt increments by 1 on every output transfer and wraps from 2^CNT_W-1 to 0.
- in_valid=1 while in_ready=0 is ignored; no data is lost and no data is duplicated.

Optional Feature:
- Macro: DSR_ROUND_MIX_EN.
- Defined: s_r = (shift_key[2r+1:2r] + round[1:0]) mod 4, using the round value sampled on accept.
- Undefined: s_r = shift_key[2r+1:2r] and the round port is ignored; the port stays present.

Test Plan:
- Reset, then in_state=128'h000102030405060708090a0b0c0d0e0f, shift_key=8'hE4, inv=0, out_ready=1 -> next cycle out_valid=1, out_state=128'h00050a0f04090e03080d02070c01060b, blk_cnt=1.
- Same in_state, shift_key=8'hE4, inv=1 -> out_state=128'h000d0a0704010e0b08050 20f0c090603 written without the space, i.e. 128'h000d0a0704010e0b0805020f0c090603. Same in_state, shift_key=8'h00 -> out_state equals in_state.
- Same in_state, shift_key=8'h1B, inv=0 -> out_state=128'h0c090603000d0a0704010e0b0805020f. With DSR_ROUND_MIX_EN, shift_key=8'h00, round=4'h1 -> every row rotates left by 1.
- Backpressure: out_ready=0, send blocks A then B -> in_ready=0 after B, out_state=A stays stable. Raise out_ready -> A then B delivered in order, in_ready returns to 1, blk_cnt advances by 2.
- Stream 20 back-to-back blocks with out_ready=1 -> one output per cycle, in_ready stays 1, outputs match a reference model.
- Assert rst while FULL -> next cycle out_valid=0, blk_cnt=0. Preset blk_cnt to 16'hFFFF, then one transfer -> blk_cnt=0.
